// File: rtl/operand_debounce2_pkg.sv
// Shared types for the operand debouncer: FSM state encoding and operand width.
package operand_debounce_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PEND   = 2'd2
    } state_e;

endpackage

// File: rtl/operand_debounce2_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; synchronous reset clears both stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/operand_debounce2.sv
// Operand debouncer: commits a 2-bit switch value after DEBOUNCE_CYCLES
// consecutive stable samples, then holds it with VALID until READY.
// Optional build macro INPUT_SYNC_EN inserts a 2-flop synchroniser on I
// (adds 2 cycles of latency); without it the FSM samples raw I.
module operand_debounce2
    import operand_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [OP_W-1:0] I,
    output logic [OP_W-1:0] O,
    output logic            VALID,
    input  logic            READY
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("operand_debounce2: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic [OP_W-1:0] sample;

`ifdef INPUT_SYNC_EN
    sync_2ff #(.W(OP_W)) u_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (I),
        .q_o   (sample)
    );
`else
    assign sample = I;
`endif

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] cand_q, cand_d;
    logic [OP_W-1:0] o_q, o_d;
    logic            valid_q, valid_d;

    // State and datapath registers; reset discards any pending operand.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: O only ever changes on the commit transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        o_d     = o_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (sample != o_q) begin
                    cand_d  = sample;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sample == o_q) begin
                    // bounced back to the committed value
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sample != cand_q) begin
                    cand_d = sample;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    o_d     = cand_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PEND: begin
                // input is ignored here; a new value is picked up from IDLE
                if (READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign O     = o_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_operand_debounce2.sv
// Directed bench for operand_debounce2 with DEBOUNCE_CYCLES=4.
// Latency expectations adapt to whether INPUT_SYNC_EN is defined.
module tb_operand_debounce2;

    localparam int DC = 4;
`ifdef INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = DC + 1 + SYNC;

    logic       CLK;
    logic       RESET;
    logic [1:0] I;
    logic [1:0] O;
    logic       VALID;
    logic       READY;

    int n_cmp;
    int n_err;

    operand_debounce2 #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .I     (I),
        .O     (O),
        .VALID (VALID),
        .READY (READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic chk_ov(input string tag, input logic [1:0] o_exp, input logic v_exp);
        chk({tag, "_O"}, O, o_exp);
        chk({tag, "_V"}, {1'b0, VALID}, {1'b0, v_exp});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESET = 1'b1;
        I     = 2'b11;
        READY = 1'b0;

        // Reset held 2 edges with I=11, then commit LAT edges after release
        step(2);
        chk_ov("rst", 2'b00, 1'b0);
        RESET = 1'b0;
        step(LAT - 1);
        chk_ov("rst_pre", 2'b00, 1'b0);
        step(1);
        chk_ov("rst_commit", 2'b11, 1'b1);
        READY = 1'b1;
        step(1);
        READY = 1'b0;
        chk_ov("rst_accept", 2'b11, 1'b0);

        // 00 -> 10, held in PEND until READY
        RESET = 1'b1;
        I     = 2'b00;
        step(2);
        RESET = 1'b0;
        step(3);
        chk_ov("idle00", 2'b00, 1'b0);
        I = 2'b10;
        step(LAT - 1);
        chk_ov("s10_pre", 2'b00, 1'b0);
        step(1);
        chk_ov("s10_commit", 2'b10, 1'b1);
        step(20);
        chk_ov("s10_hold", 2'b10, 1'b1);

        // New value during PEND is ignored until acceptance, then re-debounced
        I = 2'b11;
        step(6);
        chk_ov("pend_ign", 2'b10, 1'b1);
        READY = 1'b1;
        step(1);
        READY = 1'b0;
        chk_ov("pend_acc", 2'b10, 1'b0);
        step(DC);
        chk_ov("redeb_pre", 2'b10, 1'b0);
        step(1);
        chk_ov("redeb_commit", 2'b11, 1'b1);

        // READY already high at the commit edge: VALID still visible one cycle
        READY = 1'b1;
        step(1);
        chk_ov("rdy_acc", 2'b11, 1'b0);
        I = 2'b01;
        step(LAT - 1);
        chk_ov("rdy_pre", 2'b11, 1'b0);
        step(1);
        chk_ov("rdy_commit", 2'b01, 1'b1);
        step(1);
        chk_ov("rdy_next", 2'b01, 1'b0);
        READY = 1'b0;

        // Bounce 00->01->00->01 with 2-cycle spacing
        RESET = 1'b1;
        I     = 2'b00;
        step(2);
        RESET = 1'b0;
        step(2);
        I = 2'b01;
        step(2);
        chk_ov("bnc1", 2'b00, 1'b0);
        I = 2'b00;
        step(2);
        chk_ov("bnc2", 2'b00, 1'b0);
        I = 2'b01;
        step(LAT - 1);
        chk_ov("bnc_pre", 2'b00, 1'b0);
        step(1);
        chk_ov("bnc_commit", 2'b01, 1'b1);
        READY = 1'b1;
        step(1);
        READY = 1'b0;

        // Reset mid-SETTLE discards the candidate
        I = 2'b10;
        step(SYNC + 2);
        RESET = 1'b1;
        I     = 2'b00;
        step(1);
        chk_ov("rst_settle", 2'b00, 1'b0);
        RESET = 1'b0;
        step(10);
        chk_ov("rst_settle_after", 2'b00, 1'b0);

        // Reset mid-PEND discards the committed operand
        I = 2'b10;
        step(LAT);
        chk_ov("pend_pre_rst", 2'b10, 1'b1);
        RESET = 1'b1;
        I     = 2'b00;
        step(1);
        chk_ov("rst_pend", 2'b00, 1'b0);
        RESET = 1'b0;
        step(10);
        chk_ov("rst_pend_after", 2'b00, 1'b0);

        // Debounce still works from IDLE after reset
        I = 2'b01;
        step(LAT - 1);
        chk_ov("post_rst_pre", 2'b00, 1'b0);
        step(1);
        chk_ov("post_rst_commit", 2'b01, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_debounce2.md
OPERAND_DEBOUNCE2 -- requirements
Module: operand_debounce2

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, which is the number of consecutive stable cycles required before a new operand is committed (1 ms at 12 MHz).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 The block SHALL have port I, input, 2 bits: raw switch levels {I1,I0}, asynchronous to CLK and subject to bounce.
REQ-005 The block SHALL have port O, output, 2 bits: the debounced operand, driven straight into the downstream Negate2 stage.
REQ-006 The block SHALL have port VALID, output, 1 bit: asserted while a newly committed O awaits acceptance.
REQ-007 The block SHALL have port READY, input, 1 bit: the downstream stage accepts the committed O.

Function
REQ-008 The block SHALL define "sample" as the 2-bit input value seen by the state machine: the synchronised I, or raw I when the synchroniser is compiled out.
REQ-009 The state machine SHALL have exactly three states: IDLE, SETTLE and PEND.
REQ-010 In IDLE, when sample != O, the block SHALL load cand <= sample, clear cnt to 0 and go to SETTLE; otherwise it SHALL stay in IDLE.
REQ-011 In SETTLE, when sample == O, the block SHALL return to IDLE and clear cnt (a bounce back to the committed value).
REQ-012 In SETTLE, when sample != cand and sample != O, the block SHALL reload cand <= sample, clear cnt to 0 and stay in SETTLE.
REQ-013 In SETTLE, when sample == cand and cnt < DEBOUNCE_CYCLES-1, the block SHALL increment cnt.
REQ-014 In SETTLE, when sample == cand and cnt == DEBOUNCE_CYCLES-1, the block SHALL set O <= cand and VALID <= 1, and go to PEND.
REQ-015 In PEND, O and VALID SHALL hold; sample changes SHALL be ignored; on READY=1 the block SHALL clear VALID at that edge and go to IDLE.
REQ-016 Timing: a sample change that is stable from edge k SHALL update O and raise VALID at edge k+DEBOUNCE_CYCLES+1.
REQ-017 O SHALL change only on the commit edge of REQ-014; O SHALL never glitch and SHALL never carry an intermediate bounce value.
REQ-018 When READY is already 1 at the commit edge, VALID SHALL still be high for at least one cycle; acceptance SHALL take effect on the following edge.
REQ-019 A change to the other operand value that occurs during PEND SHALL be detected from IDLE after acceptance, with the full debounce interval restarting.
REQ-020 cnt SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap.
REQ-021 DEBOUNCE_CYCLES < 2 SHALL be rejected at elaboration.

Reset
REQ-022 While RESET=1 at an edge, the block SHALL set O=2'b00, VALID=0, state=IDLE, cnt=0, cand=2'b00 and the synchroniser flops to 0.
REQ-023 RESET SHALL take priority over every other event, including reset asserted mid-SETTLE or mid-PEND; any pending operand SHALL be discarded.
REQ-024 After reset is released, a non-zero sample SHALL begin debouncing from IDLE on the next edge.

Configuration
REQ-025 With INPUT_SYNC_EN defined, a 2-flop synchroniser SHALL sit on each bit of I, adding 2 cycles of latency (raw change to O = DEBOUNCE_CYCLES+3 edges).
REQ-026 Without INPUT_SYNC_EN, sample SHALL equal raw I (raw change to O = DEBOUNCE_CYCLES+1 edges), and the port list SHALL be unchanged.

Structure
REQ-027 Shared package operand_debounce_pkg SHALL hold the state enum (IDLE/SETTLE/PEND) and the operand width localparam OP_W=2.
REQ-028 The synchroniser SHALL be the sole sub-module, sync_2ff, instantiated once per bit, or once with width OP_W.

Verification (DEBOUNCE_CYCLES=4, INPUT_SYNC_EN defined unless stated)
REQ-029 The bench SHALL hold RESET=1 for 2 edges with I=2'b11 and then release it -> O=2'b00 and VALID=0 during reset; O=2'b11 and VALID=1 exactly 7 edges after release.
REQ-030 The bench SHALL drive I 00->10 and hold it, with READY=0 -> O=2'b10 and VALID=1 at edge 7, and O/VALID held for 20 cycles until READY pulses, after which VALID=0.
REQ-031 The bench SHALL bounce I 00->01->00->01 with 2-cycle intervals and then hold 01 -> O stays 2'b00 during the bounce; O=2'b01 exactly 7 edges after the last transition.
REQ-032 The bench SHALL drive I 11 during PEND (O=2'b10) and pulse READY -> O stays 2'b10 until acceptance; O=2'b11 and VALID=1 arrive DEBOUNCE_CYCLES+1 edges after IDLE is re-entered.
REQ-033 The bench SHALL assert RESET mid-SETTLE and mid-PEND -> O=2'b00, VALID=0 and IDLE on the next edge; no stale commit appears afterwards.
REQ-034 The bench SHALL compile without INPUT_SYNC_EN and step I 00->11 -> O=2'b11 at edge 5 (2 edges earlier than REQ-029's latency).
